// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter: state encoding,
// parameter defaults and a constant-evaluable clog2.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int DW_DEF        = 32;
  localparam int MAX_BURST_DEF = 8;

  // Bits needed to hold values 0..value-1; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first set bit of req at or after
// ptr, wrapping modulo N_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             valid,
  output logic [PW-1:0]    idx
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N_REQ]) begin
        valid = 1'b1;
        idx   = PW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers,
// granting bounded bursts and stalling on FIFO full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DW-1:0]       i_data,
  output logic [N_REQ-1:0]          o_ack,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_wr,
  output logic [DW-1:0]             o_fifo_data,
  output logic                      o_busy,
  output logic [clog2(N_REQ)-1:0]   o_owner
);

  localparam int OW = clog2(N_REQ);
  localparam int CW = clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);

  arb_state_t    state;
  logic [OW-1:0] owner;
  logic [OW-1:0] rr_ptr;
  logic [CW-1:0] burst_cnt;
  logic [OW-1:0] next_ptr;
  logic          pick_vld;
  logic [OW-1:0] pick_idx;
  logic          own_req;
  logic          take;
  logic          last_word;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (OW)
  ) u_pick (
    .req   (i_req),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign own_req   = i_req[owner];
  assign take      = (state == ARB_BURST) && own_req && !i_fifo_full;
  assign last_word = (burst_cnt == LAST_CNT);
  assign next_ptr  = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  // Full flag gates the ack in the same cycle, so a full FIFO is never written.
  always_comb begin
    o_ack       = '0;
    o_fifo_data = '0;
    if (take) begin
      o_ack[owner] = 1'b1;
      o_fifo_data  = i_data[int'(owner)*DW +: DW];
    end
  end

  assign o_fifo_wr = take;
  assign o_busy    = (state == ARB_BURST);
  assign o_owner   = owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            owner     <= pick_idx;
            burst_cnt <= '0;
            state     <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (!own_req) begin
            state  <= ARB_IDLE;
            rr_ptr <= next_ptr;
          end else if (!i_fifo_full) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (last_word) begin
              state  <= ARB_IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// cycle-level behavioural model and a queue-based 32-deep FIFO.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int MB    = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic            full;
  logic [N-1:0]    ack;
  logic            wr;
  logic [DW-1:0]   fdata;
  logic            busy;
  logic [1:0]      owner;

  logic [2:0]      req3;
  logic [3*DW-1:0] data3;
  logic            full3;
  logic [2:0]      ack3;
  logic            wr3;
  logic [DW-1:0]   fdata3;
  logic            busy3;
  logic [1:0]      owner3;

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_data(data), .o_ack(ack),
    .i_fifo_full(full), .o_fifo_wr(wr), .o_fifo_data(fdata),
    .o_busy(busy), .o_owner(owner)
  );

  fifo_wr_arbiter #(.N_REQ(3), .DW(DW), .MAX_BURST(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_req(req3), .i_data(data3), .o_ack(ack3),
    .i_fifo_full(full3), .o_fifo_wr(wr3), .o_fifo_data(fdata3),
    .o_busy(busy3), .o_owner(owner3)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [DW-1:0] fq[$];
  int            pop_n;
  logic [N-1:0]  last_ack;

  // Model: granted owner (-1 when idle), last grant, search start, words taken.
  int m_owner, m_last, m_ptr, m_cnt;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock: check outputs against the model, then advance DUT, FIFO and model.
  task automatic step();
    logic [N-1:0]  e_ack;
    logic [DW-1:0] e_data;
    logic [N-1:0]  obs_ack;
    logic          obs_wr;
    logic [DW-1:0] obs_data;
    int            w;
    #1;
    e_ack  = '0;
    e_data = '0;
    if (m_owner >= 0 && req[m_owner] && !full) begin
      e_ack[m_owner] = 1'b1;
      e_data = data[m_owner*DW +: DW];
    end
    chk("ack", ack, e_ack);
    chk("fifo_wr", wr, |e_ack);
    chk("fifo_data", fdata, e_data);
    chk("busy", busy, m_owner >= 0);
    chk("owner", owner, m_last);
    chk("wr_while_full", wr & full, 0);
    obs_ack  = ack;
    obs_wr   = wr;
    obs_data = fdata;
    @(posedge clk);
    for (int i = 0; i < pop_n && fq.size() > 0; i++) void'(fq.pop_front());
    if (obs_wr) fq.push_back(obs_data);
    if (m_owner < 0) begin
      if (req != '0) begin
        w = m_ptr;
        for (int k = 0; k < N; k++) begin
          w = (m_ptr + k) % N;
          if (req[w]) break;
        end
        m_owner = w;
        m_last  = w;
        m_cnt   = 0;
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (!full) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    full     = (fq.size() >= DEPTH);
    last_ack = obs_ack;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acked;
    int lastc;
    logic [DW-1:0] w;
    logic [DW-1:0] v;

    rst_n = 1'b0;
    req = '0; data = '0; full = 1'b0; pop_n = 0; last_ack = '0;
    req3 = '0; data3 = '0; full3 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ack", ack, 0);
    chk("rst_wr", wr, 0);
    chk("rst_data", fdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester: 10 words as bursts of 8 and 2.
    req = 4'b0001; w = 32'h100; acked = 0; lastc = -1;
    for (int c = 0; c < 40 && acked < 10; c++) begin
      data[31:0] = w;
      step();
      if (last_ack[0]) begin acked++; w++; lastc = c; end
    end
    req = '0;
    chk("single_words", acked, 10);
    chk("single_last_cycle", lastc, 11);
    chk("single_fifo_level", fq.size(), 10);
    for (int i = 0; i < 10; i++) begin
      v = (fq.size() > 0) ? fq.pop_front() : 32'hdead_beef;
      chk("single_readback", v, 32'h100 + i);
    end
    repeat (2) step();

    // Back-pressure: 30 words prefilled, requester 2 bursts 8.
    for (int i = 0; i < 30; i++) fq.push_back(i);
    full = 1'b0;
    req = 4'b0100; w = 32'h200; acked = 0;
    for (int c = 0; c < 10; c++) begin
      data[95:64] = w;
      step();
      if (last_ack[2]) begin acked++; w++; end
    end
    chk("bp_acked_before_pop", acked, 2);
    chk("bp_stall_busy", busy, 1);
    chk("bp_stall_ack", ack, 0);
    pop_n = 1;
    for (int c = 0; c < 3; c++) begin
      data[95:64] = w;
      step();
      if (last_ack[2]) begin acked++; w++; end
    end
    pop_n = 0;
    for (int c = 0; c < 6; c++) begin
      data[95:64] = w;
      step();
      if (last_ack[2]) begin acked++; w++; end
    end
    chk("bp_acked_after_pop3", acked, 5);
    pop_n = DEPTH;
    for (int c = 0; c < 20 && acked < 8; c++) begin
      data[95:64] = w;
      step();
      if (last_ack[2]) begin acked++; w++; end
    end
    req = '0;
    chk("bp_acked_total", acked, 8);
    repeat (2) step();
    pop_n = 0;

    // Early release: requester 1 drops after 3 words while 3 waits.
    req = 4'b0010; w = 32'h300; acked = 0;
    for (int c = 0; c < 10 && acked < 3; c++) begin
      data[63:32] = w;
      step();
      if (last_ack[1]) begin acked++; w++; end
    end
    chk("er_words", acked, 3);
    req = 4'b1000; data[127:96] = 32'h400;
    step();
    chk("er_idle", busy, 0);
    step();
    chk("er_owner", owner, 3);
    step();
    chk("er_ack3", last_ack, 4'b1000);
    req = '0;
    repeat (2) step();

    // Reset during the 5th word of a burst.
    pop_n = DEPTH;
    req = 4'b1111;
    data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    acked = 0;
    for (int c = 0; c < 12 && acked < 4; c++) begin
      step();
      if (last_ack != '0) acked++;
    end
    #1;
    chk("rst_mid_pre_wr", wr, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_wr", wr, 0);
    chk("rst_mid_data", fdata, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_owner", owner, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    last_ack = '0;
    step();
    step();
    chk("rst_after_owner", owner, 0);
    chk("rst_after_ack", ack, 4'b0001);

    // All four continuously requesting, new word after each ack.
    for (int c = 0; c < 90; c++) begin
      for (int k = 0; k < N; k++)
        if (last_ack[k]) data[k*DW +: DW] = $urandom;
      step();
      if (last_ack != '0) chk("onehot_owner", last_ack, 4'b0001 << m_last);
    end
    req = '0;
    repeat (2) step();

    // Random traffic honouring the hold-until-acked contract, with rare drops.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k] && last_ack[k]) begin
          req[k] = ($urandom_range(0, 1) == 1);
          data[k*DW +: DW] = $urandom;
        end else if (req[k]) begin
          if ($urandom_range(0, 31) == 0) req[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[k] = 1'b1;
          data[k*DW +: DW] = $urandom;
        end
      end
      pop_n = $urandom_range(0, 2);
      step();
    end
    req = '0;
    pop_n = 0;
    repeat (2) step();

    // Wrap-around: 3 requesters, single-word bursts, requesters 0 and 2 active.
    req3 = 3'b101;
    data3 = {32'hC2, 32'hC1, 32'hC0};
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk("wrap_ack_idle", ack3, 3'b000);
        chk("wrap_busy_idle", busy3, 0);
      end else if (i % 4 == 1) begin
        chk("wrap_ack0", ack3, 3'b001);
        chk("wrap_owner0", owner3, 0);
        chk("wrap_data0", fdata3, 32'hC0);
      end else begin
        chk("wrap_ack2", ack3, 3'b100);
        chk("wrap_owner2", owner3, 2);
        chk("wrap_data2", fdata3, 32'hC2);
      end
      @(posedge clk); #1;
    end
    req3 = '0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
